// File: rtl/controle_jogo.sv
// controle_jogo -- game-logic sequencer feeding the tela renderer.
//
// Once per video frame (frame_tick) it moves the ship, both bullets and the
// enemy, then resolves collisions, lives and score on the following cycle.
// A start / play / game-over state machine gates all of this.
//
// Ports:
//   CLOCK_50                       system clock
//   reset                          synchronous, active-high
//   frame_tick                     one-cycle pulse per frame (CLOCK_50 domain)
//   btn_esq, btn_dir               ship left / right (levels)
//   btn_tiro, btn_start            fire / start (levels, edge-detected here)
//   ativo, perdeu                  renderer mode
//   x_nave, y_nave                 ship top-left, active-area coordinates
//   x_inimigo, y_inimigo           enemy top-left, active-area coordinates
//   inimigo_vivo                   enemy visible / collidable
//   x/y/raio_bola_aliada           player bullet centre (active) and radius
//   x/y/raio_bola_inimiga          enemy bullet centre (raw VGA timing) and radius
//   vidas, pontos                  remaining lives, score
// A bullet is inactive exactly when its radius is 0; its coordinates are 0 then.
module controle_jogo #(
    parameter int LARGURA_TELA   = 640,
    parameter int ALTURA_TELA    = 480,
    parameter int VEL_NAVE       = 4,
    parameter int VEL_BOLA       = 8,
    parameter int VEL_INIMIGO    = 2,
    parameter int VIDAS_INICIAIS = 3,
    parameter int RAIO_BOLA      = 4,
    parameter int PERIODO_TIRO   = 90,
    parameter int ESPERA_RESPAWN = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_esq,
    input  logic       btn_dir,
    input  logic       btn_tiro,
    input  logic       btn_start,
    output logic       ativo,
    output logic       perdeu,
    output logic [9:0] x_nave,
    output logic [9:0] y_nave,
    output logic [9:0] x_inimigo,
    output logic [9:0] y_inimigo,
    output logic       inimigo_vivo,
    output logic [9:0] x_bola_aliada,
    output logic [9:0] y_bola_aliada,
    output logic [9:0] raio_bola_aliada,
    output logic [9:0] x_bola_inimiga,
    output logic [9:0] y_bola_inimiga,
    output logic [9:0] raio_bola_inimiga,
    output logic [1:0] vidas,
    output logic [7:0] pontos
);

    // Sprite sizes are the source bitmaps scaled by 3.
    localparam logic [9:0] LARG_NAVE     = 10'd45;
    localparam logic [9:0] ALT_NAVE      = 10'd51;
    localparam logic [9:0] LARG_INIMIGO  = 10'd33;
    localparam logic [9:0] ALT_INIMIGO   = 10'd24;
    localparam logic [9:0] X_NAVE_INI    = 10'((LARGURA_TELA - 45) / 2);
    localparam logic [9:0] Y_NAVE_INI    = 10'(ALTURA_TELA - 51 - 8);
    localparam logic [9:0] Y_INIMIGO_INI = 10'd40;
    localparam logic [9:0] X_NAVE_MAX    = 10'(LARGURA_TELA - 45);
    localparam logic [9:0] X_INIMIGO_MAX = 10'(LARGURA_TELA - 33);
    localparam logic [9:0] V_NAVE        = 10'(VEL_NAVE);
    localparam logic [9:0] V_BOLA        = 10'(VEL_BOLA);
    localparam logic [9:0] V_INIMIGO     = 10'(VEL_INIMIGO);
    localparam logic [9:0] RAIO          = 10'(RAIO_BOLA);
    // The enemy bullet is kept directly in raw VGA timing coordinates.
    localparam logic [9:0] OFS_X         = 10'd144;
    localparam logic [9:0] OFS_Y         = 10'd35;
    localparam logic [9:0] Y_LIMITE_RAW  = 10'(ALTURA_TELA + 35);
    localparam int W_TIRO = $clog2(PERIODO_TIRO + 1);
    localparam int W_RESP = $clog2(ESPERA_RESPAWN + 1);

    typedef enum logic [2:0] {ESPERA, JOGANDO, MOVE, COLIDE, FIM} estado_t;

    estado_t           estado_reg;
    logic              dir_inimigo_reg;   // 1 = moving right
    logic              tiro_pend_reg;
    logic              tiro_ant_reg;
    logic              start_ant_reg;
    logic [W_TIRO-1:0] cnt_tiro_reg;
    logic [W_RESP-1:0] cnt_respawn_reg;

    logic tiro_sobe, start_sobe, hit_aliada, hit_inimiga, volta_inicio;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tiro_ant_reg  <= 1'b0;
            start_ant_reg <= 1'b0;
        end else begin
            tiro_ant_reg  <= btn_tiro;
            start_ant_reg <= btn_start;
        end
    end

    assign tiro_sobe  = btn_tiro & ~tiro_ant_reg;
    assign start_sobe = btn_start & ~start_ant_reg;
    // Leaving game-over restores exactly the reset state, so it shares that path.
    assign volta_inicio = (estado_reg == FIM) && start_sobe;

    assign hit_aliada = (raio_bola_aliada != 10'd0) && inimigo_vivo
        && (x_bola_aliada >= x_inimigo) && (x_bola_aliada < x_inimigo + LARG_INIMIGO)
        && (y_bola_aliada >= y_inimigo) && (y_bola_aliada < y_inimigo + ALT_INIMIGO);

    // Ship box shifted into raw coordinates instead of un-offsetting the bullet.
    assign hit_inimiga = (raio_bola_inimiga != 10'd0)
        && (x_bola_inimiga >= x_nave + OFS_X) && (x_bola_inimiga < x_nave + OFS_X + LARG_NAVE)
        && (y_bola_inimiga >= y_nave + OFS_Y) && (y_bola_inimiga < y_nave + OFS_Y + ALT_NAVE);

    always_ff @(posedge CLOCK_50) begin
        if (reset || volta_inicio) begin
            estado_reg        <= ESPERA;
            ativo             <= 1'b0;
            perdeu            <= 1'b0;
            x_nave            <= X_NAVE_INI;
            y_nave            <= Y_NAVE_INI;
            x_inimigo         <= 10'd0;
            y_inimigo         <= Y_INIMIGO_INI;
            inimigo_vivo      <= 1'b1;
            dir_inimigo_reg   <= 1'b1;
            x_bola_aliada     <= 10'd0;
            y_bola_aliada     <= 10'd0;
            raio_bola_aliada  <= 10'd0;
            x_bola_inimiga    <= 10'd0;
            y_bola_inimiga    <= 10'd0;
            raio_bola_inimiga <= 10'd0;
            vidas             <= 2'(VIDAS_INICIAIS);
            pontos            <= 8'd0;
            cnt_tiro_reg      <= '0;
            cnt_respawn_reg   <= '0;
            tiro_pend_reg     <= 1'b0;
        end else begin
            case (estado_reg)
                ESPERA: begin
                    if (start_sobe) begin
                        estado_reg    <= JOGANDO;
                        ativo         <= 1'b1;
                        vidas         <= 2'(VIDAS_INICIAIS);
                        pontos        <= 8'd0;
                        tiro_pend_reg <= 1'b0;
                    end
                end
                JOGANDO: begin
                    if (frame_tick) estado_reg <= MOVE;
                end
                MOVE: begin
                    // Ship: opposite buttons cancel out.
                    if (btn_esq && !btn_dir)
                        x_nave <= (x_nave < V_NAVE) ? 10'd0 : x_nave - V_NAVE;
                    else if (btn_dir && !btn_esq)
                        x_nave <= (x_nave > X_NAVE_MAX - V_NAVE) ? X_NAVE_MAX : x_nave + V_NAVE;

                    // Player bullet: a fresh spawn does not move in its spawn frame.
                    if (raio_bola_aliada != 10'd0) begin
                        if (y_bola_aliada < V_BOLA) begin
                            x_bola_aliada    <= 10'd0;
                            y_bola_aliada    <= 10'd0;
                            raio_bola_aliada <= 10'd0;
                        end else begin
                            y_bola_aliada <= y_bola_aliada - V_BOLA;
                        end
                    end else if (tiro_pend_reg) begin
                        x_bola_aliada    <= x_nave + 10'd22;
                        y_bola_aliada    <= (y_nave == 10'd0) ? 10'd0 : y_nave - 10'd1;
                        raio_bola_aliada <= RAIO;
                    end
                    tiro_pend_reg <= 1'b0;

                    // Enemy: bounce between the screen edges, or count down to respawn.
                    if (inimigo_vivo) begin
                        if (dir_inimigo_reg) begin
                            if (x_inimigo > X_INIMIGO_MAX - V_INIMIGO) begin
                                x_inimigo       <= X_INIMIGO_MAX;
                                dir_inimigo_reg <= 1'b0;
                            end else begin
                                x_inimigo <= x_inimigo + V_INIMIGO;
                            end
                        end else begin
                            if (x_inimigo < V_INIMIGO) begin
                                x_inimigo       <= 10'd0;
                                dir_inimigo_reg <= 1'b1;
                            end else begin
                                x_inimigo <= x_inimigo - V_INIMIGO;
                            end
                        end
                    end else if (cnt_respawn_reg == W_RESP'(ESPERA_RESPAWN - 1)) begin
                        inimigo_vivo    <= 1'b1;
                        x_inimigo       <= 10'd0;
                        dir_inimigo_reg <= 1'b1;
                        cnt_respawn_reg <= '0;
                    end else begin
                        cnt_respawn_reg <= cnt_respawn_reg + 1'b1;
                    end

                    // Enemy fire cadence runs every frame, even while the enemy is dead.
                    if (cnt_tiro_reg == W_TIRO'(PERIODO_TIRO - 1)) begin
                        cnt_tiro_reg <= '0;
                        if (raio_bola_inimiga == 10'd0 && inimigo_vivo) begin
                            x_bola_inimiga    <= x_inimigo + 10'd16 + OFS_X;
                            y_bola_inimiga    <= y_inimigo + ALT_INIMIGO + OFS_Y;
                            raio_bola_inimiga <= RAIO;
                        end
                    end else begin
                        cnt_tiro_reg <= cnt_tiro_reg + 1'b1;
                    end

                    if (raio_bola_inimiga != 10'd0) begin
                        if (y_bola_inimiga + V_BOLA >= Y_LIMITE_RAW) begin
                            x_bola_inimiga    <= 10'd0;
                            y_bola_inimiga    <= 10'd0;
                            raio_bola_inimiga <= 10'd0;
                        end else begin
                            y_bola_inimiga <= y_bola_inimiga + V_BOLA;
                        end
                    end
                    estado_reg <= COLIDE;
                end
                COLIDE: begin
                    if (hit_aliada) begin
                        x_bola_aliada    <= 10'd0;
                        y_bola_aliada    <= 10'd0;
                        raio_bola_aliada <= 10'd0;
                        inimigo_vivo     <= 1'b0;
                        if (pontos != 8'hFF) pontos <= pontos + 8'd1;
                    end
                    if (hit_inimiga && vidas != 2'd0) begin
                        x_bola_inimiga    <= 10'd0;
                        y_bola_inimiga    <= 10'd0;
                        raio_bola_inimiga <= 10'd0;
                        vidas             <= vidas - 2'd1;
                    end
                    if (hit_inimiga && vidas == 2'd1) begin
                        estado_reg <= FIM;
                        perdeu     <= 1'b1;
                    end else begin
                        estado_reg <= JOGANDO;
                    end
                end
                FIM: begin
                    // Frozen; btn_start is handled by the restore path above.
                end
                default: estado_reg <= ESPERA;
            endcase
            // A new fire press wins over the MOVE-cycle clear.
            if (tiro_sobe) tiro_pend_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: frame-level game model plus directed scenarios.
module tb_controle_jogo;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0, frame_tick = 1'b0;
    logic       btn_esq = 1'b0, btn_dir = 1'b0, btn_tiro = 1'b0, btn_start = 1'b0;
    logic       ativo, perdeu, inimigo_vivo;
    logic [9:0] x_nave, y_nave, x_inimigo, y_inimigo;
    logic [9:0] x_bola_aliada, y_bola_aliada, raio_bola_aliada;
    logic [9:0] x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic [1:0] vidas;
    logic [7:0] pontos;

    controle_jogo dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
        .btn_esq(btn_esq), .btn_dir(btn_dir), .btn_tiro(btn_tiro), .btn_start(btn_start),
        .ativo(ativo), .perdeu(perdeu),
        .x_nave(x_nave), .y_nave(y_nave),
        .x_inimigo(x_inimigo), .y_inimigo(y_inimigo), .inimigo_vivo(inimigo_vivo),
        .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada),
        .raio_bola_aliada(raio_bola_aliada),
        .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga),
        .raio_bola_inimiga(raio_bola_inimiga),
        .vidas(vidas), .pontos(pontos)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Game state in active-area pixels; mode 0 = waiting, 1 = playing, 2 = lost.
    typedef struct {
        int mode; int sx; int ex; int eright; int alive; int resp; int shot;
        int pbl; int pbx; int pby; int ebl; int ebx; int eby;
        int lives; int score; int pend;
    } model_t;

    model_t m;
    int     checks = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.sx = 297; r.ex = 0; r.eright = 1; r.alive = 1; r.resp = 0;
        r.shot = 0; r.pbl = 0; r.pbx = 0; r.pby = 0; r.ebl = 0; r.ebx = 0;
        r.eby = 0; r.lives = 3; r.score = 0; r.pend = 0;
        return r;
    endfunction

    // One whole frame: movement from the old state, then collisions on the result.
    function automatic model_t step(model_t s, bit esq, bit dir);
        model_t n = s;
        int nx;
        if (s.mode != 1) return s;
        if (esq && !dir) n.sx = (s.sx - 4 < 0) ? 0 : s.sx - 4;
        else if (dir && !esq) n.sx = (s.sx + 4 > 595) ? 595 : s.sx + 4;
        if (s.pbl != 0) begin
            if (s.pby < 8) begin n.pbl = 0; n.pbx = 0; n.pby = 0; end
            else n.pby = s.pby - 8;
        end else if (s.pend != 0) begin
            n.pbl = 1; n.pbx = s.sx + 22; n.pby = 420;
        end
        n.pend = 0;
        if (s.alive != 0) begin
            nx = s.ex + ((s.eright != 0) ? 2 : -2);
            if (nx > 607) begin nx = 607; n.eright = 0; end
            else if (nx < 0) begin nx = 0; n.eright = 1; end
            n.ex = nx;
        end else begin
            n.resp = s.resp + 1;
            if (n.resp == 60) begin n.alive = 1; n.ex = 0; n.eright = 1; n.resp = 0; end
        end
        n.shot = s.shot + 1;
        if (n.shot == 90) begin
            n.shot = 0;
            if (s.ebl == 0 && s.alive != 0) begin n.ebl = 1; n.ebx = s.ex + 16; n.eby = 64; end
        end
        if (s.ebl != 0) begin
            n.eby = s.eby + 8;
            if (n.eby >= 480) begin n.ebl = 0; n.ebx = 0; n.eby = 0; end
        end
        if (n.pbl != 0 && n.alive != 0 && n.pbx >= n.ex && n.pbx < n.ex + 33
            && n.pby >= 40 && n.pby < 64) begin
            n.pbl = 0; n.pbx = 0; n.pby = 0; n.alive = 0;
            if (n.score < 255) n.score = n.score + 1;
        end
        if (n.ebl != 0 && n.ebx >= n.sx && n.ebx < n.sx + 45 && n.eby >= 421 && n.eby < 472) begin
            n.ebl = 0; n.ebx = 0; n.eby = 0; n.lives = n.lives - 1;
            if (n.lives == 0) n.mode = 2;
        end
        return n;
    endfunction

    // Would a shot fired now (ship idle) score within the next 60 frames?
    function automatic bit predict_hit(model_t s);
        model_t t = s;
        t.pend = 1;
        for (int k = 0; k < 60; k++) begin
            t = step(t, 1'b0, 1'b0);
            if (t.score > s.score) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("ativo", int'(ativo), (m.mode != 0) ? 1 : 0);
            chk("perdeu", int'(perdeu), (m.mode == 2) ? 1 : 0);
            chk("x_nave", int'(x_nave), m.sx);
            chk("y_nave", int'(y_nave), 421);
            chk("x_inimigo", int'(x_inimigo), m.ex);
            chk("y_inimigo", int'(y_inimigo), 40);
            chk("inimigo_vivo", int'(inimigo_vivo), m.alive);
            chk("x_bola_aliada", int'(x_bola_aliada), m.pbx);
            chk("y_bola_aliada", int'(y_bola_aliada), m.pby);
            chk("raio_bola_aliada", int'(raio_bola_aliada), (m.pbl != 0) ? 4 : 0);
            chk("x_bola_inimiga", int'(x_bola_inimiga), (m.ebl != 0) ? m.ebx + 144 : 0);
            chk("y_bola_inimiga", int'(y_bola_inimiga), (m.ebl != 0) ? m.eby + 35 : 0);
            chk("raio_bola_inimiga", int'(raio_bola_inimiga), (m.ebl != 0) ? 4 : 0);
            chk("vidas", int'(vidas), m.lives);
            chk("pontos", int'(pontos), m.score);
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        chk_en = 1'b0;
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        m = model_reset();
        chk_en = 1'b1;
        tick();
    endtask

    task automatic frame(input bit esq, input bit dir);
        btn_esq = esq;
        btn_dir = dir;
        chk_en = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        m = step(m, esq, dir);
        chk_en = 1'b1;
        tick();
        btn_esq = 1'b0;
        btn_dir = 1'b0;
    endtask

    task automatic press_start();
        chk_en = 1'b0;
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        if (m.mode == 0) begin
            m.mode = 1; m.lives = 3; m.score = 0; m.pend = 0;
        end else if (m.mode == 2) begin
            m = model_reset();
        end
        chk_en = 1'b1;
        tick();
    endtask

    task automatic press_tiro();
        btn_tiro = 1'b1;
        tick();
        btn_tiro = 1'b0;
        m.pend = 1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        model_t nxt;
        int     sx_saved, tgt, c;
        m = model_reset();
        tick();

        // Reset state.
        do_reset(2);
        chk("rst_ativo", int'(ativo), 0);
        chk("rst_x_nave", int'(x_nave), 297);
        chk("rst_y_nave", int'(y_nave), 421);
        chk("rst_vivo", int'(inimigo_vivo), 1);
        chk("rst_vidas", int'(vidas), 3);
        chk("rst_pontos", int'(pontos), 0);
        chk("rst_raio_a", int'(raio_bola_aliada), 0);
        chk("rst_raio_i", int'(raio_bola_inimiga), 0);
        $display("reset done: x_nave=%0d vidas=%0d", x_nave, vidas);

        // frame_tick while waiting is ignored.
        frame(1'b0, 1'b1);
        chk("espera_x_nave", int'(x_nave), 297);

        // Start, then three frames moving right.
        press_start();
        repeat (3) frame(1'b0, 1'b1);
        chk("play_ativo", int'(ativo), 1);
        chk("move_x_nave", int'(x_nave), 309);
        chk("move_x_inimigo", int'(x_inimigo), 6);
        $display("after 3 frames: x_nave=%0d x_inimigo=%0d", x_nave, x_inimigo);

        // Fire: spawn frame then one move.
        press_tiro();
        frame(1'b0, 1'b0);
        chk("spawn_x", int'(x_bola_aliada), 331);
        chk("spawn_y", int'(y_bola_aliada), 420);
        chk("spawn_raio", int'(raio_bola_aliada), 4);
        frame(1'b0, 1'b0);
        chk("bullet_y2", int'(y_bola_aliada), 412);
        $display("bullet: x=%0d y=%0d", x_bola_aliada, y_bola_aliada);

        // Right edge clamp, then left edge floor.
        repeat (72) frame(1'b0, 1'b1);
        chk("cap_x_nave", int'(x_nave), 595);
        frame(1'b0, 1'b1);
        chk("cap_hold", int'(x_nave), 595);
        repeat (149) frame(1'b1, 1'b0);
        chk("floor_x_nave", int'(x_nave), 0);
        $display("edges: x_nave=%0d", x_nave);

        // Score a hit, then wait for the respawn.
        do_reset(2);
        press_start();
        for (int f = 0; f < 400 && m.score == 0; f++) begin
            if (m.pbl == 0 && m.pend == 0 && predict_hit(m)) press_tiro();
            frame(1'b0, 1'b0);
        end
        chk("hit_pontos", int'(pontos), 1);
        chk("hit_vivo", int'(inimigo_vivo), 0);
        chk("hit_raio_a", int'(raio_bola_aliada), 0);
        $display("hit: pontos=%0d vivo=%0d", pontos, inimigo_vivo);
        repeat (59) frame(1'b0, 1'b0);
        chk("respawn_wait", int'(inimigo_vivo), 0);
        frame(1'b0, 1'b0);
        chk("respawn_vivo", int'(inimigo_vivo), 1);
        chk("respawn_x", int'(x_inimigo), 0);
        $display("respawn: vivo=%0d x=%0d", inimigo_vivo, x_inimigo);

        // Track the enemy until three lives are lost.
        do_reset(2);
        press_start();
        for (int f = 0; f < 600 && m.mode == 1; f++) begin
            tgt = (m.ebl != 0) ? m.ebx : m.ex + 16;
            c = m.sx + 22;
            frame(c > tgt + 2, c < tgt - 2);
        end
        chk("over_vidas", int'(vidas), 0);
        chk("over_perdeu", int'(perdeu), 1);
        chk("over_ativo", int'(ativo), 1);
        sx_saved = m.sx;
        repeat (3) frame(1'b0, 1'b1);
        chk("over_frozen_x", int'(x_nave), sx_saved);
        $display("game over: vidas=%0d perdeu=%0d x_nave=%0d", vidas, perdeu, x_nave);
        press_start();
        chk("restart_ativo", int'(ativo), 0);
        chk("restart_perdeu", int'(perdeu), 0);
        chk("restart_x_nave", int'(x_nave), 297);
        chk("restart_x_inimigo", int'(x_inimigo), 0);
        chk("restart_vidas", int'(vidas), 3);
        chk("restart_raio_i", int'(raio_bola_inimiga), 0);
        $display("restart: ativo=%0d vidas=%0d", ativo, vidas);

        // Reset landing on the collision cycle of a scoring frame.
        do_reset(2);
        press_start();
        for (int f = 0; f < 400; f++) begin
            if (m.pbl == 0 && m.pend == 0 && predict_hit(m)) press_tiro();
            nxt = step(m, 1'b0, 1'b0);
            if (nxt.score > m.score) break;
            frame(1'b0, 1'b0);
        end
        chk_en = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m = model_reset();
        chk_en = 1'b1;
        chk("rstcol_pontos", int'(pontos), 0);
        chk("rstcol_vivo", int'(inimigo_vivo), 1);
        chk("rstcol_raio_a", int'(raio_bola_aliada), 0);
        chk("rstcol_x_inimigo", int'(x_inimigo), 0);
        chk("rstcol_ativo", int'(ativo), 0);
        chk("rstcol_vidas", int'(vidas), 3);
        $display("reset in collide: pontos=%0d vivo=%0d", pontos, inimigo_vivo);
        tick();
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
